// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a 2-flop input synchronizer,
// mid-bit sampling, a single-entry output holding register with
// valid/ack handshake, and one-cycle frame-error / overrun pulses.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle; waiting for rx_s to fall
// START | counting to mid start bit; low there confirms the start bit
// DATA  | sampling 8 data bits, LSB first, once per bit period
// STOP  | sampling the stop bit; high accepts the byte, low is an error
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Uart_rx,
    input  logic       Rx_ack,
    output logic [7:0] Rx_data,
    output logic       Rx_valid,
    output logic       Frame_err,
    output logic       Overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_meta;
    logic             rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a falling edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM plus registered outputs; a byte accept in STOP overrides
    // a same-cycle ack, so the ack clear is written first.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            Rx_data   <= 8'h00;
            Rx_valid  <= 1'b0;
            Frame_err <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            Frame_err <= 1'b0;
            Overrun   <= 1'b0;
            if (Rx_ack && Rx_valid) begin
                Rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        bit_idx            <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            Rx_data  <= shift_reg;
                            Rx_valid <= 1'b1;
                            Overrun  <= Rx_valid && !Rx_ack;
                        end else begin
                            Frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a byte-level
// reference model (holding register, valid flag, pulse counts).
module tb_uart_receiver;

    localparam int CPB = 16;
    // Cycles from driving the start-bit edge to the accept becoming visible:
    // 2 sync + 1 idle detect + half bit + 9 full bits (data + stop).
    localparam int ACC_LAT = 3 + CPB / 2 + 9 * CPB;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Uart_rx;
    logic       Rx_ack;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Frame_err;
    logic       Overrun;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int fe_cyc = -1;
    int ov_cyc = -1;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;

    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Uart_rx   (Uart_rx),
        .Rx_ack    (Rx_ack),
        .Rx_data   (Rx_data),
        .Rx_valid  (Rx_valid),
        .Frame_err (Frame_err),
        .Overrun   (Overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Frame_err) begin
            fe_seen++;
            fe_cyc = cyc;
        end
        if (Overrun) begin
            ov_seen++;
            ov_cyc = cyc;
        end
        if (Rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = Rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, 32'(Rx_valid), 32'(exp_valid));
        chk({tag, "_data"}, 32'(Rx_data), 32'(exp_data));
        chk({tag, "_fe_count"}, fe_seen, exp_fe);
        chk({tag, "_ov_count"}, ov_seen, exp_ov);
    endtask

    // Behavioural view of one complete frame arriving.
    function automatic void model_frame(input logic [7:0] d, input logic stop, input logic ack_acc);
        if (stop) begin
            if (exp_valid && !ack_acc) exp_ov++;
            exp_data  = d;
            exp_valid = 1'b1;
        end else begin
            exp_fe++;
            if (ack_acc) exp_valid = 1'b0;
        end
    endfunction

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
    endtask

    // Drives one 10-bit frame; optional ack lands on the stop-sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_acc,
                              output int t0);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10 * CPB; i++) begin
            Uart_rx = bits[i / CPB];
            Rx_ack  = ack_acc && (i == ACC_LAT - 1);
            @(posedge Clk);
            #1;
        end
        Uart_rx = 1'b1;
        Rx_ack  = 1'b0;
        model_frame(d, stop, ack_acc);
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) begin
            Uart_rx = 1'b1;
            Rx_ack  = ack && (i == 0);
            @(posedge Clk);
            #1;
        end
        Rx_ack = 1'b0;
        if (ack && n > 0) exp_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int t0;
        int t1;
        logic [7:0] d;
        logic stop;
        logic ack_acc;
        int gap;
        logic [9:0] bits;

        Rst     = 1'b1;
        Uart_rx = 1'b1;
        Rx_ack  = 1'b0;
        exp_fe  = 0;
        exp_ov  = 0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_data", 32'(Rx_data), 32'h00);
        chk("reset_valid", 32'(Rx_valid), 32'h0);
        chk("reset_frame_err", 32'(Frame_err), 32'h0);
        chk("reset_overrun", 32'(Overrun), 32'h0);
        Rst = 1'b0;
        idle(5, 1'b0);

        // Ack with nothing pending is ignored.
        idle(3, 1'b1);
        check_all("ack_idle");

        // Single frame, latency, then consume.
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        chk("a5_latency", rise_cyc - t0, ACC_LAT);
        check_all("a5");
        idle(1, 1'b1);
        check_all("a5_acked");
        idle(8, 1'b0);

        // Back-to-back frames without ack -> overrun on the second.
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        send_frame(8'hC3, 1'b1, 1'b0, t1);
        chk("ovr_latency", ov_cyc - t1, ACC_LAT);
        check_all("b2b_overrun");
        idle(1, 1'b1);

        // Back-to-back with ack on the second accept -> no overrun.
        send_frame(8'h3C, 1'b1, 1'b0, t0);
        send_frame(8'hC3, 1'b1, 1'b1, t1);
        check_all("b2b_ack_acc");
        idle(1, 1'b1);
        idle(8, 1'b0);

        // Framing error from reset state, then a good frame.
        pulse_reset();
        idle(4, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, t0);
        chk("fe_latency", fe_cyc - t0, ACC_LAT);
        check_all("frame_err");
        idle(3 * CPB, 1'b0);
        check_all("frame_err_idle");
        send_frame(8'h81, 1'b1, 1'b0, t0);
        check_all("after_fe_81");

        // Short low glitch is rejected.
        for (int i = 0; i < 5; i++) begin
            Uart_rx = 1'b0;
            @(posedge Clk);
            #1;
        end
        idle(3 * CPB, 1'b0);
        check_all("glitch");
        send_frame(8'h7E, 1'b1, 1'b0, t0);
        check_all("after_glitch_7e");

        // Reset in the middle of bit 4 of 0xFF, with ack asserted during reset.
        bits = {1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 5 * CPB + 8; i++) begin
            Uart_rx = bits[i / CPB];
            @(posedge Clk);
            #1;
        end
        Rst    = 1'b1;
        Rx_ack = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst    = 1'b0;
        Rx_ack = 1'b0;
        model_reset();
        chk("midreset_data", 32'(Rx_data), 32'h00);
        chk("midreset_valid", 32'(Rx_valid), 32'h0);
        idle(6 * CPB, 1'b0);
        check_all("midreset_quiet");
        send_frame(8'h12, 1'b1, 1'b0, t0);
        check_all("after_reset_12");

        // Randomized frames, gaps and acks.
        for (int n = 0; n < 30; n++) begin
            d       = 8'($urandom_range(0, 255));
            stop    = ($urandom_range(0, 4) != 0);
            ack_acc = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, ack_acc, t0);
            check_all("rand_frame");
            if (!stop) gap = 3 * CPB + $urandom_range(0, 20);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = $urandom_range(1, 30);
            idle(gap, (gap > 0) && ($urandom_range(0, 1) == 1));
            check_all("rand_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Parameters
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning Clk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.

Interface
REQ-002 SHALL have port Clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port Rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port Uart_rx, input, 1, asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port Rx_data, output, 8, last correctly received byte.
REQ-006 SHALL have port Rx_valid, output, 1, level; high while Rx_data holds an unconsumed byte.
REQ-007 SHALL have port Rx_ack, input, 1, consumer pulse; marks Rx_data consumed.
REQ-008 SHALL have port Frame_err, output, 1, one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port Overrun, output, 1, one-cycle pulse; new byte overwrote an unconsumed byte.

Function
REQ-010 SHALL pass Uart_rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle input latency).
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, with bit-period counter clk_cnt (width clog2(CLKS_PER_BIT)) and 3-bit bit index.
REQ-012 IDLE: clk_cnt held at 0; rx_s==0 -> START.
REQ-013 START: clk_cnt increments; at clk_cnt==CLKS_PER_BIT/2-1 (integer division): rx_s==0 -> DATA with clk_cnt=0 and bit index=0; rx_s==1 -> IDLE (glitch rejected, no output activity).
REQ-014 DATA: at clk_cnt==CLKS_PER_BIT-1, rx_s shifts into shift-register position bit index, clk_cnt=0, bit index increments; after bit 7 -> STOP.
REQ-015 STOP: at clk_cnt==CLKS_PER_BIT-1: rx_s==1 -> byte accepted; rx_s==0 -> Frame_err=1 for exactly that cycle, byte discarded, Rx_data/Rx_valid unchanged; either case -> IDLE next cycle.
REQ-016 Byte accept: Rx_data<=shift register, Rx_valid<=1, both visible the cycle after the STOP sample.
REQ-017 Rx_ack with Rx_valid==1 and no simultaneous accept: Rx_valid<=0 next cycle; Rx_data retained.
REQ-018 Rx_ack with Rx_valid==0: ignored.
REQ-019 Accept with Rx_valid==1 and Rx_ack==0 same cycle: Rx_data overwritten, Rx_valid stays 1, Overrun=1 for one cycle.
REQ-020 Accept and Rx_ack same cycle: accept wins; Rx_valid stays 1, new data loaded, no Overrun.
REQ-021 After STOP->IDLE, a falling edge immediately following the stop sample SHALL start a new frame (back-to-back frames at full rate).
REQ-022 Line held low after framing error: IDLE sees rx_s==0 -> START again; each failed frame produces its own Frame_err pulse.

Reset
REQ-023 Rst==1 at a rising edge: state=IDLE, clk_cnt=0, bit index=0, shift register=0, synchronizer flops=1, Rx_data=8'h00, Rx_valid=0, Frame_err=0, Overrun=0.
REQ-024 Rst asserted mid-frame SHALL abort the frame with no Rx_valid, Frame_err or Overrun; after release a frame is recognised only from a fresh start bit.
REQ-025 Rst has priority over Rx_ack and every FSM transition in the same cycle.

Verification (CLKS_PER_BIT=16)
REQ-026 Frame 0xA5, stop=1 -> Rx_data=0xA5, Rx_valid=1 from cycle after stop sample; Rx_ack pulse -> Rx_valid=0 next cycle, Rx_data stays 0xA5.
REQ-027 Frames 0x3C then 0xC3 back-to-back, no Rx_ack -> Rx_data=0xC3, Rx_valid=1, one Overrun pulse at second accept; Rx_ack coincident with second accept -> no Overrun.
REQ-028 Frame 0x55 with stop bit driven low -> one-cycle Frame_err, Rx_valid remains 0, Rx_data remains 0x00; next valid frame 0x81 received correctly.
REQ-029 Uart_rx low pulse of 5 cycles from idle -> return to IDLE, no Rx_valid/Frame_err; following frame 0x7E received correctly.
REQ-030 Rst pulsed at bit 4 of frame 0xFF -> all outputs at reset values, no pulses; next frame 0x12 -> Rx_data=0x12, Rx_valid=1.
